pipe_adder: RTL and testbench

Parametrised, pipelined binary adder/subtractor with valid/ready handshaking on both sides. The WIDTH-bit operands are split into SEG-bit segments, and each pipeline stage adds one segment using a combinational ripple chain. Each stage registers its carry into the next stage. The block is the wide-datapath successor of the fixed 8-bit ripple adder: it trades latency for clock rate and sits between a producer and a consumer on streaming arithmetic paths.

---
 rtl/pipe_adder_pkg.sv | 19 +
 rtl/pipe_adder_if.sv | 39 +++
 rtl/pipe_adder_seg_add.sv | 26 ++
 rtl/pipe_adder.sv | 133 +++++++++++++
 tb/tb_pipe_adder.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_adder_pkg.sv
// pipe_adder_pkg: shared constants and helpers for the pipelined adder.
// Holds the default operand/segment widths, the stage-count function and
// the configuration sanity check used at elaboration by the top level.
package pipe_adder_pkg;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_SEG   = 8;

   // Number of pipeline stages: one stage per SEG-bit segment.
   function automatic int stages_f(input int width, input int seg);
      return width / seg;
   endfunction

   // True when the operand width splits into a whole number (>= 1) of segments.
   function automatic bit cfg_ok(input int width, input int seg);
      return (seg > 0) && (width >= seg) && ((width % seg) == 0);
   endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// pipe_adder_if: operand/result stream bundle for pipe_adder.
// The ovf signal only exists when PIPE_ADDER_OVF_EN is defined.
// slave = the adder itself, master = the producer/consumer side.
interface pipe_adder_if
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] s;
   logic             cout;
`ifdef PIPE_ADDER_OVF_EN
   logic             ovf;
`endif

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, s, cout
`ifdef PIPE_ADDER_OVF_EN
      , ovf
`endif
   );

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, s, cout
`ifdef PIPE_ADDER_OVF_EN
      , ovf
`endif
   );

endinterface

// File: rtl/pipe_adder_seg_add.sv
// seg_add: purely combinational SEG-bit ripple-carry adder built from
// full adders; one instance does the arithmetic for one pipeline stage.
module seg_add
   import pipe_adder_pkg::*;
#(
   parameter int SEG = DEF_SEG
) (
   input  logic [SEG-1:0] x,
   input  logic [SEG-1:0] y,
   input  logic           ci,
   output logic [SEG-1:0] sum,
   output logic           co
);

   logic [SEG:0] c;

   assign c[0] = ci;

   for (genvar gi = 0; gi < SEG; gi++) begin : g_fa
      assign sum[gi]  = x[gi] ^ y[gi] ^ c[gi];
      assign c[gi+1]  = (x[gi] & y[gi]) | (c[gi] & (x[gi] ^ y[gi]));
   end

   assign co = c[SEG];

endmodule

// File: rtl/pipe_adder.sv
// pipe_adder: pipelined WIDTH-bit adder/subtractor, one SEG-bit segment per
// stage, valid/ready on both sides with a single global stall (adv).
// Optional signed-overflow output enabled by defining PIPE_ADDER_OVF_EN.
module pipe_adder
   import pipe_adder_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int SEG   = DEF_SEG
) (
   input logic         clk,
   input logic         rst,
   pipe_adder_if.slave bus
);

   localparam int STAGES = stages_f(WIDTH, SEG);
   localparam int MSB    = WIDTH - 1;

   if (!cfg_ok(WIDTH, SEG)) begin : g_cfg_check
      $error("pipe_adder: WIDTH (%0d) must be a positive multiple of SEG (%0d)", WIDTH, SEG);
   end

   logic             adv;

   // Inputs seen by stage k (stage 0 from the port, others from stage k-1).
   logic [WIDTH-1:0] in_a [STAGES];
   logic [WIDTH-1:0] in_b [STAGES];
   logic [WIDTH-1:0] in_s [STAGES];
   logic             in_c [STAGES];
   logic             in_v [STAGES];

   // Registered outputs of stage k and its combinational next partial sum.
   logic [WIDTH-1:0] reg_a [STAGES];
   logic [WIDTH-1:0] reg_b [STAGES];
   logic [WIDTH-1:0] reg_s [STAGES];
   logic             reg_c [STAGES];
   logic             reg_v [STAGES];
   logic [WIDTH-1:0] nxt_s [STAGES];

   // The whole pipe moves only when the output slot is empty or being taken.
   assign adv          = !reg_v[STAGES-1] || bus.out_ready;
   assign bus.in_ready = adv;

   // Subtraction is A + ~B + 1, so cin is overridden by sub.
   assign in_a[0] = bus.a;
   assign in_b[0] = bus.sub ? ~bus.b : bus.b;
   assign in_c[0] = bus.sub | bus.cin;
   assign in_s[0] = '0;
   assign in_v[0] = bus.in_valid;

   for (genvar gi = 1; gi < STAGES; gi++) begin : g_link
      assign in_a[gi] = reg_a[gi-1];
      assign in_b[gi] = reg_b[gi-1];
      assign in_s[gi] = reg_s[gi-1];
      assign in_c[gi] = reg_c[gi-1];
      assign in_v[gi] = reg_v[gi-1];
   end

   for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      logic [SEG-1:0]   seg_sum;
      logic             seg_co;
      logic [WIDTH-1:0] s_d;
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             c_q;
      logic             v_q;

      seg_add #(.SEG(SEG)) u_seg_add (
         .x   (in_a[gi][gi*SEG +: SEG]),
         .y   (in_b[gi][gi*SEG +: SEG]),
         .ci  (in_c[gi]),
         .sum (seg_sum),
         .co  (seg_co)
      );

      // Splice this stage's segment into the partial sum carried so far.
      always_comb begin
         s_d                 = in_s[gi];
         s_d[gi*SEG +: SEG]  = seg_sum;
      end

      // Stage register; data only loads for real beats so s holds across bubbles.
      always_ff @(posedge clk) begin
         if (rst) begin
            v_q <= 1'b0;
            c_q <= 1'b0;
            s_q <= '0;
            a_q <= '0;
            b_q <= '0;
         end else if (adv) begin
            v_q <= in_v[gi];
            if (in_v[gi]) begin
               c_q <= seg_co;
               s_q <= s_d;
               a_q <= in_a[gi];
               b_q <= in_b[gi];
            end
         end
      end

      assign reg_a[gi] = a_q;
      assign reg_b[gi] = b_q;
      assign reg_s[gi] = s_q;
      assign reg_c[gi] = c_q;
      assign reg_v[gi] = v_q;
      assign nxt_s[gi] = s_d;
   end

   assign bus.out_valid = reg_v[STAGES-1];
   assign bus.s         = reg_s[STAGES-1];
   assign bus.cout      = reg_c[STAGES-1];

`ifdef PIPE_ADDER_OVF_EN
   logic ovf_d;
   logic ovf_q;

   // Operand signs arrive with the beat at the last stage (forwarded A/B').
   assign ovf_d = (in_a[STAGES-1][MSB] == in_b[STAGES-1][MSB]) &&
                  (nxt_s[STAGES-1][MSB] != in_a[STAGES-1][MSB]);

   // Overflow flag registered alongside the final sum segment.
   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (adv && in_v[STAGES-1]) begin
         ovf_q <= ovf_d;
      end
   end

   assign bus.ovf = ovf_q;
`endif

endmodule

// File: tb/tb_pipe_adder.sv
// tb_pipe_adder: scoreboard bench for pipe_adder (WIDTH=32, SEG=8).
// Expected results are queued at accept time and compared on delivery.
`timescale 1ns/1ps
module tb_pipe_adder;
   import pipe_adder_pkg::*;

   localparam int WIDTH  = 32;
   localparam int SEG    = 8;
   localparam int STAGES = stages_f(WIDTH, SEG);

   typedef struct {
      logic [WIDTH-1:0] s;
      logic             cout;
      logic             ovf;
      int               cyc;
      bit               lat;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pipe_adder_if #(.WIDTH(WIDTH)) bus ();

   pipe_adder #(.WIDTH(WIDTH), .SEG(SEG)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   exp_t sb[$];
   int   cyc      = 0;
   int   n_checks = 0;
   int   n_pass   = 0;
   bit   lat_mode = 1'b1;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: transfers happen at the next rising edge; inputs are stable here.
   always @(negedge clk) begin
      exp_t             e;
      exp_t             n;
      logic [WIDTH-1:0] bp;
      logic [WIDTH:0]   full;
      if (rst) begin
         sb.delete();
      end else begin
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               check_val("spurious_out", 64'(1), 64'(0));
            end else begin
               e = sb.pop_front();
               check_val("sum", 64'(bus.s), 64'(e.s));
               check_val("cout", 64'(bus.cout), 64'(e.cout));
`ifdef PIPE_ADDER_OVF_EN
               check_val("ovf", 64'(bus.ovf), 64'(e.ovf));
`endif
               if (e.lat) check_val("latency", 64'(cyc - e.cyc), 64'(STAGES));
               $display("result cyc=%0d s=%08h cout=%b exp_s=%08h exp_cout=%b", cyc, bus.s, bus.cout, e.s, e.cout);
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            bp     = bus.sub ? ~bus.b : bus.b;
            full   = {1'b0, bus.a} + {1'b0, bp} + (WIDTH+1)'(bus.sub | bus.cin);
            n.s    = full[WIDTH-1:0];
            n.cout = full[WIDTH];
            n.ovf  = (bus.a[WIDTH-1] == bp[WIDTH-1]) && (full[WIDTH-1] != bus.a[WIDTH-1]);
            n.cyc  = cyc;
            n.lat  = lat_mode;
            sb.push_back(n);
         end
      end
   end

   task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin, input logic sub);
      int waited;
      waited       = 0;
      bus.a        = a;
      bus.b        = b;
      bus.cin      = cin;
      bus.sub      = sub;
      bus.in_valid = 1'b1;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) check_val("in_ready_timeout", 64'(0), 64'(1));
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         #1;
         n++;
      end
      check_val("drain", 64'(sb.size()), 64'(0));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.cin       = 1'b0;
      bus.sub       = 1'b0;
      bus.out_ready = 1'b1;
      rst           = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      check_val("rst_out_valid", 64'(bus.out_valid), 64'(0));
      check_val("rst_s", 64'(bus.s), 64'(0));
      check_val("rst_cout", 64'(bus.cout), 64'(0));
      check_val("rst_in_ready", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;

      // Directed vectors: cross-stage carry, full wrap, subtraction, overflow
      send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
      wait_drain();
      send(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
      wait_drain();
      send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
      send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
      send(32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1);
      send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
      send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
      wait_drain();

      // Back-to-back stream of 10 random beats
      for (int i = 0; i < 10; i++) begin
         send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      wait_drain();

      // Fill the pipe with the consumer stalled, then hold for 6 cycles
      lat_mode      = 1'b0;
      bus.out_ready = 1'b0;
      for (int i = 0; i < STAGES; i++) begin
         send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0);
      end
      bus.a        = 32'h1234_5678;
      bus.b        = 32'h0000_1111;
      bus.cin      = 1'b1;
      bus.sub      = 1'b0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_val("stall_in_ready", 64'(bus.in_ready), 64'(0));
         check_val("stall_out_valid", 64'(bus.out_valid), 64'(1));
         if (sb.size() > 0) check_val("stall_s", 64'(bus.s), 64'(sb[0].s));
         else check_val("stall_sb_empty", 64'(0), 64'(1));
      end
      @(posedge clk);
      #1;
      bus.out_ready = 1'b1;
      send(32'h1234_5678, 32'h0000_1111, 1'b1, 1'b0);
      wait_drain();
      lat_mode = 1'b1;

      // Reset with three beats in flight: none may come out
      send(32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
      send(32'h0000_0003, 32'h0000_0004, 1'b0, 1'b0);
      send(32'h0000_0005, 32'h0000_0006, 1'b0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check_val("rst_mid_in_ready", 64'(bus.in_ready), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b0;
      for (int i = 0; i < STAGES + 2; i++) begin
         @(negedge clk);
         check_val("post_rst_out_valid", 64'(bus.out_valid), 64'(0));
      end
      check_val("post_rst_s", 64'(bus.s), 64'(0));
      check_val("post_rst_cout", 64'(bus.cout), 64'(0));
      @(posedge clk);
      #1;

      // First beat after reset completes with normal latency
      send(32'hDEAD_BEEF, 32'h0101_0101, 1'b0, 1'b0);
      wait_drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
